// File: rtl/mem_xfer_if.sv
// mem_xfer_if: bus between the control FSM and the memory-transfer sequencer.
//   start/mode/ri/rj : transfer request (mode 0 = STORE, 1 = LOAD)
//   mfc              : memory function complete from memory
//   reg_read/write   : one-hot register bus enables
//   mar_*/mdr_*      : MAR/MDR bus and memory-side enables
//   mem_en/mem_rw    : memory request, 1 = read
//   busy/done/err    : status; done/err are one-cycle pulses
interface mem_xfer_if #(
    parameter int NUM_REGS = 5,
    parameter int SEL_W    = 6
);
    logic                start;
    logic                mode;
    logic [SEL_W-1:0]    ri;
    logic [SEL_W-1:0]    rj;
    logic                mfc;
    logic [NUM_REGS-1:0] reg_read;
    logic [NUM_REGS-1:0] reg_write;
    logic                mar_write;
    logic                mdr_write;
    logic                mdr_read;
    logic                mdr_mem_read;
    logic                mdr_mem_write;
    logic                mem_en;
    logic                mem_rw;
    logic                busy;
    logic                done;
    logic                err;

    modport slave (
        input  start, mode, ri, rj, mfc,
        output reg_read, reg_write, mar_write, mdr_write, mdr_read,
               mdr_mem_read, mdr_mem_write, mem_en, mem_rw, busy, done, err
    );

    modport master (
        output start, mode, ri, rj, mfc,
        input  reg_read, reg_write, mar_write, mdr_write, mdr_read,
               mdr_mem_read, mdr_mem_write, mem_en, mem_rw, busy, done, err
    );
endinterface

// File: rtl/mem_xfer_fsm.sv
// mem_xfer_fsm: sequences one LOAD or STORE between the register file and
// memory through MAR/MDR with a bounded MFC wait.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : mem_xfer_if.slave (request in, bus/memory enables and status out)
// Outputs are registered from the next state, so they behave as pure Moore
// outputs of the current state while coming straight out of flops.
module mem_xfer_fsm #(
    parameter int NUM_REGS = 5,
    parameter int SEL_W    = 6,
    parameter int TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       reset,
    mem_xfer_if.slave  bus
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [3:0] {
        S_IDLE, S_DATA, S_ADDR, S_REQ, S_WAIT, S_LATCH, S_XFER, S_DONE, S_ERR
    } state_t;

    state_t           state, nxt;
    logic [SEL_W-1:0] ri_q, rj_q, n_ri, n_rj;
    logic             mode_q, n_mode;
    logic [CNT_W-1:0] cnt, n_cnt;

    logic [NUM_REGS-1:0] o_rr, o_rw;
    logic o_marw, o_mdrw, o_mdrr, o_mmr, o_mmw, o_en, o_mrw, o_busy, o_done, o_err;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_REGS-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[i] = (sel == SEL_W'(i));
        return v;
    endfunction

    // Next state and captured request
    always_comb begin
        nxt    = state;
        n_ri   = ri_q;
        n_rj   = rj_q;
        n_mode = mode_q;
        n_cnt  = cnt;
        case (state)
            S_IDLE: if (bus.start) begin
                n_ri   = bus.ri;
                n_rj   = bus.rj;
                n_mode = bus.mode;
                // Out-of-range selects abort before any bus activity
                if (32'(bus.ri) >= NUM_REGS || 32'(bus.rj) >= NUM_REGS) nxt = S_ERR;
                else nxt = bus.mode ? S_ADDR : S_DATA;
            end
            S_DATA:  nxt = S_ADDR;
            S_ADDR:  nxt = S_REQ;
            S_REQ: begin
                n_cnt = '0;
                nxt   = S_WAIT;
            end
            S_WAIT: begin
                // mfc takes priority over an expiring timeout
                if (bus.mfc) nxt = mode_q ? S_LATCH : S_DONE;
                else if (TIMEOUT > 0 && cnt == CNT_LAST) nxt = S_ERR;
                else if (cnt != '1) n_cnt = cnt + 1'b1;
            end
            S_LATCH: nxt = S_XFER;
            S_XFER:  nxt = S_DONE;
            S_DONE:  nxt = S_IDLE;
            S_ERR:   nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Output decode of the state being entered
    always_comb begin
        o_rr = '0; o_rw = '0;
        o_marw = 1'b0; o_mdrw = 1'b0; o_mdrr = 1'b0; o_mmr = 1'b0; o_mmw = 1'b0;
        o_en = 1'b0; o_mrw = 1'b0; o_done = 1'b0; o_err = 1'b0;
        o_busy = (nxt != S_IDLE);
        case (nxt)
            S_DATA: begin
                o_rr   = onehot(n_ri);
                o_mdrw = 1'b1;
            end
            S_ADDR: begin
                o_rr   = onehot(n_rj);
                o_marw = 1'b1;
            end
            S_REQ, S_WAIT: begin
                o_en  = 1'b1;
                o_mrw = n_mode;
                o_mmr = ~n_mode;
            end
            S_LATCH: begin
                o_en  = 1'b1;
                o_mrw = 1'b1;
                o_mmw = 1'b1;
            end
            S_XFER: begin
                o_mdrr = 1'b1;
                o_rw   = onehot(n_ri);
            end
            S_DONE: o_done = 1'b1;
            S_ERR: begin
                o_done = 1'b1;
                o_err  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            ri_q              <= '0;
            rj_q              <= '0;
            mode_q            <= 1'b0;
            cnt               <= '0;
            bus.reg_read      <= '0;
            bus.reg_write     <= '0;
            bus.mar_write     <= 1'b0;
            bus.mdr_write     <= 1'b0;
            bus.mdr_read      <= 1'b0;
            bus.mdr_mem_read  <= 1'b0;
            bus.mdr_mem_write <= 1'b0;
            bus.mem_en        <= 1'b0;
            bus.mem_rw        <= 1'b0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.err           <= 1'b0;
        end else begin
            state             <= nxt;
            ri_q              <= n_ri;
            rj_q              <= n_rj;
            mode_q            <= n_mode;
            cnt               <= n_cnt;
            bus.reg_read      <= o_rr;
            bus.reg_write     <= o_rw;
            bus.mar_write     <= o_marw;
            bus.mdr_write     <= o_mdrw;
            bus.mdr_read      <= o_mdrr;
            bus.mdr_mem_read  <= o_mmr;
            bus.mdr_mem_write <= o_mmw;
            bus.mem_en        <= o_en;
            bus.mem_rw        <= o_mrw;
            bus.busy          <= o_busy;
            bus.done          <= o_done;
            bus.err           <= o_err;
        end
    end
endmodule

// File: tb/tb_mem_xfer_fsm.sv
// tb_mem_xfer_fsm: drives transfers into a TIMEOUT=4 instance and a
// TIMEOUT=0 instance sharing the same request inputs. Each transfer is
// expanded by a transaction-level model into the expected per-cycle output
// trace, which is compared cycle by cycle.
module tb_mem_xfer_fsm;
    localparam int NR = 5;
    localparam int SW = 6;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_xfer_if #(.NUM_REGS(NR), .SEL_W(SW)) b4 ();
    mem_xfer_if #(.NUM_REGS(NR), .SEL_W(SW)) b0 ();

    assign b0.start = b4.start;
    assign b0.mode  = b4.mode;
    assign b0.ri    = b4.ri;
    assign b0.rj    = b4.rj;
    assign b0.mfc   = b4.mfc;

    mem_xfer_fsm #(.NUM_REGS(NR), .SEL_W(SW), .TIMEOUT(TO)) dut4 (.clk(clk), .reset(reset), .bus(b4));
    mem_xfer_fsm #(.NUM_REGS(NR), .SEL_W(SW), .TIMEOUT(0))  dut0 (.clk(clk), .reset(reset), .bus(b0));

    // {reg_read, reg_write, mar_w, mdr_w, mdr_r, mdr_mem_r, mdr_mem_w, mem_en, mem_rw, busy, done, err}
    logic [19:0] obs4, obs0;
    assign obs4 = {b4.reg_read, b4.reg_write, b4.mar_write, b4.mdr_write, b4.mdr_read,
                   b4.mdr_mem_read, b4.mdr_mem_write, b4.mem_en, b4.mem_rw, b4.busy, b4.done, b4.err};
    assign obs0 = {b0.reg_read, b0.reg_write, b0.mar_write, b0.mdr_write, b0.mdr_read,
                   b0.mdr_mem_read, b0.mdr_mem_write, b0.mem_en, b0.mem_rw, b0.busy, b0.done, b0.err};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [19:0] w(input logic [4:0] rr, input logic [4:0] rw,
                                      input logic marw, mdrw, mdrr, mmr, mmw, en, mrw,
                                      input logic bsy, dn, er);
        return {rr, rw, marw, mdrw, mdrr, mmr, mmw, en, mrw, bsy, dn, er};
    endfunction

    function automatic logic [4:0] oh(input int x);
        return 5'(1 << x);
    endfunction

    // Precondition: called #1 after a posedge with the DUT idle in this cycle.
    // d = WAIT cycles with mfc low before mfc rises; d >= TO times out.
    task automatic run_xfer(input logic mode, input int ri, input int rj, input int d, input bit junk);
        logic [19:0] exp[$];
        int tm;
        bit  tmo;
        tmo = (d >= TO);
        if (ri >= NR || rj >= NR) begin
            exp.push_back(w(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        end else begin
            if (!mode) exp.push_back(w(oh(ri), 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
            exp.push_back(w(oh(rj), 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
            repeat (1 + (tmo ? TO : d + 1))
                exp.push_back(w(0, 0, 0, 0, 0, !mode, 0, 1, mode, 1, 0, 0));
            if (tmo) exp.push_back(w(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
            else begin
                if (mode) begin
                    exp.push_back(w(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0));
                    exp.push_back(w(0, oh(ri), 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
                end
                exp.push_back(w(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
            end
        end
        // first WAIT cycle is cycle 3 (load) or 4 (store)
        tm = tmo ? 1000 : (mode ? 3 : 4) + d;
        b4.start = 1'b1;
        b4.mode  = mode;
        b4.ri    = SW'(ri);
        b4.rj    = SW'(rj);
        b4.mfc   = 1'b0;
        @(negedge clk);
        check("idle_before", obs4, 0);
        @(posedge clk); #1;
        for (int k = 1; k <= exp.size(); k++) begin
            b4.mfc = (k >= tm);
            if (junk) begin
                b4.start = 1'($urandom);
                b4.mode  = 1'($urandom);
                b4.ri    = SW'($urandom_range(0, 7));
                b4.rj    = SW'($urandom_range(0, 7));
            end else begin
                b4.start = 1'b0;
            end
            @(negedge clk);
            check($sformatf("xfer_m%0d_c%0d", mode, k), obs4, exp[k-1]);
            @(posedge clk); #1;
        end
        b4.start = 1'b0;
        b4.mfc   = 1'b0;
    endtask

    task automatic idle_cycle();
        b4.start = 1'b0;
        b4.mfc   = 1'b0;
        @(negedge clk);
        check("idle", obs4, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset    = 1'b1;
        b4.start = 1'b0;
        b4.mode  = 1'b0;
        b4.ri    = '0;
        b4.rj    = '0;
        b4.mfc   = 1'b0;
        @(negedge clk);
        check("reset_state4", obs4, 0);
        check("reset_state0", obs0, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_xfer(1'b0, 2, 1, 0, 0);   // store, mfc already high
        idle_cycle();
        run_xfer(1'b1, 4, 0, 3, 0);   // load, mfc late
        run_xfer(1'b0, 3, 2, 10, 0);  // back-to-back, timeout
        idle_cycle();
        run_xfer(1'b1, 1, 3, TO - 1, 0); // mfc on the expiry cycle
        run_xfer(1'b0, 7, 1, 0, 0);   // bad select ri
        run_xfer(1'b1, 0, 5, 0, 0);   // bad select rj
        run_xfer(1'b1, 2, 4, 1, 1);   // inputs thrashed while busy
        run_xfer(1'b0, 0, 3, 2, 1);

        for (int i = 0; i < 40; i++) begin
            run_xfer(1'($urandom), $urandom_range(0, 6), $urandom_range(0, 6),
                     $urandom_range(0, 6), 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

        // TIMEOUT=0 waits forever; then reset during that load's WAIT
        b4.start = 1'b1;
        b4.mode  = 1'b1;
        b4.ri    = SW'(4);
        b4.rj    = SW'(0);
        b4.mfc   = 1'b0;
        @(posedge clk); #1;
        b4.start = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            check($sformatf("t0_wait_%0d", k), {b0.busy, b0.mem_en, b0.mem_rw, b0.done}, 4'b1110);
            @(posedge clk); #1;
        end
        #2 reset = 1'b1;
        #1;
        check("async_reset0", obs0, 0);
        check("async_reset4", obs4, 0);
        @(posedge clk); #1;
        check("reset_hold0", obs0, 0);
        reset = 1'b0;
        run_xfer(1'b0, 1, 4, 1, 0);
        idle_cycle();
        check("t0_idle_after", obs0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/mem_xfer_fsm.md
Name: mem_xfer_fsm

Overview:
Parametrised memory-transfer controller that sequences one LOAD or STORE between the register file and memory over the shared bus, using MAR/MDR and the MFC handshake. It generalises the single-mode store sequencer to:
- N registers, with one-hot read and write enables;
- both transfer directions;
- a bounded MFC wait with timeout and error reporting.
It sits under the main control FSM and is started once per memory instruction.

Parameters:
NUM_REGS, 5, number of bus-attached registers (general registers plus port); width of the reg_read/reg_write vectors
SEL_W, 6, width of the ri/rj register selects
TIMEOUT, 16, maximum WAIT cycles without MFC before error; 0 disables the timeout (wait forever)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a transfer; sampled only in IDLE
mode  in  1  0 = STORE (reg[ri] -> mem[reg[rj]]), 1 = LOAD (mem[reg[rj]] -> reg[ri])
ri  in  SEL_W  data register select
rj  in  SEL_W  address register select
mfc  in  1  memory function complete, level
reg_read  out  NUM_REGS  one-hot; selected register drives the bus
reg_write  out  NUM_REGS  one-hot; selected register latches from the bus
mar_write  out  1  MAR latches from the bus
mdr_write  out  1  MDR latches from the bus
mdr_read  out  1  MDR drives the bus
mdr_mem_read  out  1  MDR drives memory write data
mdr_mem_write  out  1  MDR latches memory read data
mem_en  out  1  memory request
mem_rw  out  1  1 = read, 0 = write
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of transfer (success or error)
err  out  1  one-cycle pulse together with done when the transfer was aborted

Behaviour:
- Reset: asynchronous, state -> IDLE, wait counter cleared, every output 0. Reset mid-operation abandons the transfer; no done pulse.
- Moore outputs, decoded from state and latched selects only. Any output not listed for a state is 0.
- Capture at start: in IDLE with start=1, ri, rj and mode are latched. Later changes on these inputs are ignored until the next IDLE.
- Select range check at start: if latched ri >= NUM_REGS or rj >= NUM_REGS -> go to ERR. No bus or memory activity occurs.
- Start outside IDLE: ignored and not queued.
- States:
  - IDLE: outputs 0. start -> DATA (mode 0) or ADDR (mode 1).
  - DATA (store only): reg_read[ri]=1, mdr_write=1 -> ADDR.
  - ADDR: reg_read[rj]=1, mar_write=1 -> REQ.
  - REQ: mem_en=1, mem_rw=mode; mdr_mem_read=1 when store. Wait counter cleared -> WAIT.
  - WAIT: same outputs as REQ, held. mfc=1 -> DONE (store) or LATCH (load). Otherwise counter++. If TIMEOUT>0 and counter reaches TIMEOUT-1 with mfc=0 -> ERR. mfc=1 on the same cycle as expiry: mfc wins.
  - LATCH (load only): mem_en=1, mem_rw=1, mdr_mem_write=1 -> XFER.
  - XFER (load only): mdr_read=1, reg_write[ri]=1 -> DONE.
  - DONE: done=1 -> IDLE.
  - ERR: done=1, err=1 -> IDLE.
  - Unused encodings -> IDLE.
- Latency, start sampled at edge 0 and mfc already high:
  - store: done high in cycle 5;
  - load: done high in cycle 6;
  - each extra WAIT cycle adds 1.
- Timing guarantees:
  - reg_read and reg_write are never both nonzero in the same cycle.
  - At most one bit of each vector is set.
  - mem_en is high only in REQ, WAIT and LATCH.
- Back-to-back: start held high in the IDLE cycle that follows DONE begins the next transfer. The minimum gap between transfers is one IDLE cycle.
- Wait counter width: clog2(TIMEOUT+1), saturating; it never wraps.

Test Plan:
- Store, ri=2, rj=1, mfc high from start -> reg_read=00100 in cycle 1 with mdr_write; 00010 in cycle 2 with mar_write. mem_en=1, mem_rw=0 in cycles 3-4; done=1, err=0 in cycle 5; busy falls in cycle 6.
- Load, ri=4, rj=0, mfc delayed 3 cycles -> mem_en/mem_rw=1 held through WAIT. mdr_mem_write one cycle after mfc, then reg_write=10000 with mdr_read, then done pulse. reg_read is 00000 in XFER.
- Timeout, TIMEOUT=4, mfc held 0 -> exactly 4 WAIT cycles, then done=1 and err=1 for one cycle, then IDLE with all outputs 0. A repeat run with TIMEOUT=0 and mfc=0 for 100 cycles -> still in WAIT, no done.
- Bad select ri=7 -> cycle 1 is ERR (done=err=1), and no reg_read, mar_write or mem_en ever asserted.
- Reset asserted during WAIT of a load -> all outputs 0 immediately (asynchronous), no done. start after release runs a full store correctly.
- start toggled and ri/rj changed while busy -> transfer completes with the originally latched selects; exactly one done pulse.
